// File: rtl/knight_rider_pkg.sv
// ============================================================================
// Module   : knight_rider_pkg
// Brief    : Shared constants, FSM state type and ring-index-to-LED fold.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package knight_rider_pkg;

   localparam int N_LED  = 8;
   localparam int N_RING = 2*N_LED - 2;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Up-sweep indices map straight through; the down-sweep mirrors back.
   function automatic int fold_idx(input int idx, input int n_led);
      return (idx < n_led) ? idx : (2*n_led - 2 - idx);
   endfunction

endpackage

`default_nettype wire

// File: rtl/kr_onehot_enc.sv
// ============================================================================
// Module   : kr_onehot_enc
// Brief    : One-hot to binary index encoder with exact-one-hot valid flag.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module kr_onehot_enc #(
   parameter int N = 14,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_idx,
   output logic         o_valid
);

   // OR-reduction of set positions; only meaningful when o_valid is high.
   always_comb begin
      o_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (i_vec[k]) o_idx = o_idx | W'(k);
      end
   end

   assign o_valid = $onehot(i_vec);

endmodule

`default_nettype wire

// File: rtl/knight_rider_decoder.sv
// ============================================================================
// Module   : knight_rider_decoder
// Brief    : Locks onto the 14-stage one-hot ring and folds it to the 8-LED
//            bounce pattern; error counter present when KNIGHT_RIDER_ERR_CNT_EN
//            is defined, otherwise err_cnt_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module knight_rider_decoder #(
   parameter int N_LED    = knight_rider_pkg::N_LED,
   parameter int LOCK_CNT = 2,
   parameter int CNT_W    = 8
) (
   input  logic                     clk_i,
   input  logic                     sys_rst_i,
   input  logic                     enable_i,
   input  logic [2*N_LED-3:0]       counter_i,
   output logic [N_LED-1:0]         led_o,
   output logic [$clog2(N_LED)-1:0] pos_o,
   output logic                     dir_o,
   output logic                     locked_o,
   output logic                     err_o,
   output logic [CNT_W-1:0]         err_cnt_o
);
   import knight_rider_pkg::*;

   localparam int C_RING_LEN = 2*N_LED - 2;
   localparam int C_IDX_W    = $clog2(C_RING_LEN);
   localparam int C_POS_W    = $clog2(N_LED);
   localparam int C_RUN_W    = $clog2(LOCK_CNT + 1);

   state_t               r_state, w_state_nxt;
   logic [C_IDX_W-1:0]   r_exp_idx, w_exp_idx_nxt;
   logic [C_RUN_W-1:0]   r_run, w_run_nxt;
   logic [N_LED-1:0]     r_led, w_led_nxt;
   logic [C_POS_W-1:0]   r_pos, w_pos_nxt;
   logic                 r_dir, w_dir_nxt;
   logic                 r_err, w_err_nxt;

   logic [C_IDX_W-1:0]   w_idx, w_idx_inc;
   logic                 w_valid, w_match;
   logic [C_POS_W-1:0]   w_smp_pos;
   logic [N_LED-1:0]     w_smp_led;
   logic                 w_smp_dir;
   logic [C_RUN_W-1:0]   w_run_inc;

   kr_onehot_enc #(
      .N (C_RING_LEN),
      .W (C_IDX_W)
   ) u_enc (
      .i_vec   (counter_i),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   assign w_idx_inc = (w_idx == C_IDX_W'(C_RING_LEN - 1)) ? '0 : w_idx + C_IDX_W'(1);
   assign w_match   = w_valid && (w_idx == r_exp_idx);
   assign w_smp_pos = C_POS_W'(fold_idx(int'(w_idx), N_LED));
   assign w_smp_led = {{(N_LED-1){1'b0}}, 1'b1} << w_smp_pos;
   assign w_smp_dir = (w_idx >= C_IDX_W'(N_LED));
   assign w_run_inc = r_run + C_RUN_W'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_exp_idx_nxt = r_exp_idx;
      w_run_nxt     = r_run;
      w_led_nxt     = r_led;
      w_pos_nxt     = r_pos;
      w_dir_nxt     = r_dir;
      w_err_nxt     = 1'b0;
      if (enable_i) begin
         case (r_state)
            SEARCH: begin
               if (w_valid) begin
                  w_exp_idx_nxt = w_idx_inc;
                  w_run_nxt     = '0;
                  w_state_nxt   = VERIFY;
               end
            end
            VERIFY: begin
               if (w_match) begin
                  w_exp_idx_nxt = w_idx_inc;
                  w_run_nxt     = w_run_inc;
                  if (w_run_inc == C_RUN_W'(LOCK_CNT)) begin
                     w_state_nxt = LOCKED;
                     w_led_nxt   = w_smp_led;
                     w_pos_nxt   = w_smp_pos;
                     w_dir_nxt   = w_smp_dir;
                  end
               end else begin
                  w_state_nxt = SEARCH;
               end
            end
            LOCKED: begin
               if (w_match) begin
                  w_exp_idx_nxt = w_idx_inc;
                  w_led_nxt     = w_smp_led;
                  w_pos_nxt     = w_smp_pos;
                  w_dir_nxt     = w_smp_dir;
               end else begin
                  // The breaking sample is discarded, not used as a new seed.
                  w_err_nxt   = 1'b1;
                  w_state_nxt = SEARCH;
                  w_run_nxt   = '0;
                  w_led_nxt   = '0;
                  w_pos_nxt   = '0;
                  w_dir_nxt   = 1'b0;
               end
            end
            default: w_state_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         r_state   <= SEARCH;
         r_exp_idx <= '0;
         r_run     <= '0;
         r_led     <= '0;
         r_pos     <= '0;
         r_dir     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_exp_idx <= w_exp_idx_nxt;
         r_run     <= w_run_nxt;
         r_led     <= w_led_nxt;
         r_pos     <= w_pos_nxt;
         r_dir     <= w_dir_nxt;
         r_err     <= w_err_nxt;
      end
   end

`ifdef KNIGHT_RIDER_ERR_CNT_EN
   logic [CNT_W-1:0] r_err_cnt;

   always_ff @(posedge clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         r_err_cnt <= '0;
      end else if (w_err_nxt && (r_err_cnt != {CNT_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign err_cnt_o = r_err_cnt;
`else
   assign err_cnt_o = {CNT_W{1'b0}};
`endif

   assign led_o    = r_led;
   assign pos_o    = r_pos;
   assign dir_o    = r_dir;
   assign locked_o = (r_state == LOCKED);
   assign err_o    = r_err;

endmodule

`default_nettype wire

// File: doc/knight_rider_decoder.md
# knight_rider_decoder

Receive-side companion to the 14-stage ring counter that drives the Knight Rider display. The block samples the 14-bit one-hot ring state and checks that it is legal and advancing in sequence. Once it has locked onto the sequence, it folds the state into the 8-LED bounce pattern and reports position, sweep direction and sequence errors. It sits between the ring counter and the LED pins or status logic.

## Interface
Parameters:
- N_LED, 8, LED count; ring length N_RING = 2*N_LED-2 (14)
- LOCK_CNT, 2, consecutive in-sequence steps required before lock
- CNT_W, 8, error counter width

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- sys_rst_i  in  1  reset; asynchronous, active-high
- enable_i  in  1  ring-step strobe; counter_i is sampled only when high
- counter_i  in  N_RING  one-hot ring state; bit k set means the ring is at index k
- led_o  out  N_LED  one-hot LED pattern; all zero when not locked
- pos_o  out  3  lit LED number (0..N_LED-1)
- dir_o  out  1  0 = sweeping up (index 0..7), 1 = sweeping down (index 8..13)
- locked_o  out  1  high while in LOCKED
- err_o  out  1  one-cycle pulse on a sequence break while LOCKED
- err_cnt_o  out  CNT_W  saturating error count

## Operation
- Valid sample: counter_i is exactly one-hot. Zero or multi-hot is invalid.
- Index k maps to LED number: k for k ≤ 7, and 14-k for k ≥ 8. The sweep is therefore 0,1,…,7,6,…,1,0,…
- `exp_idx` holds the expected next index. It advances as (k+1) mod 14, so index 13 wraps to 0.
- FSM states SEARCH, VERIFY, LOCKED; reset state is SEARCH.
  - SEARCH: on an enabled valid sample, set exp_idx = k+1 mod 14, clear `run`, go to VERIFY. Invalid samples leave the FSM in SEARCH.
  - VERIFY: on an enabled sample equal to onehot(exp_idx), increment `run` and advance exp_idx. When `run` reaches LOCK_CNT, go to LOCKED. On any other sample, go to SEARCH with no error.
  - LOCKED: on an enabled matching sample, update led_o, pos_o and dir_o, and advance exp_idx. On a mismatch (including invalid), pulse err_o, increment err_cnt_o, and go to SEARCH.
- The mismatching sample is never reused as a search seed. Re-acquisition starts with the next enabled sample.
- enable_i low: all state and outputs hold, and err_o is 0.
- err_cnt_o saturates at 2^CNT_W-1.

## Timing
- All outputs are registered and reflect the sample taken on the previous enabled edge (latency 1 cycle).
- locked_o rises in the cycle after the LOCK_CNT-th matching sample. On that same transition led_o, pos_o and dir_o load that sample's LED.
- On an error: err_o=1, locked_o=0 and led_o=0, all in the same cycle after the bad sample.
- Reset values: led_o=0, pos_o=0, dir_o=0, locked_o=0, err_o=0, err_cnt_o=0. FSM is in SEARCH and run=0.
- Reset asserted mid-operation clears all state immediately, independent of clk_i. The first edge after deassertion is treated as SEARCH.

## Configuration
- KNIGHT_RIDER_ERR_CNT_EN defined: the err_cnt_o counter is implemented as described.
- KNIGHT_RIDER_ERR_CNT_EN undefined: no counter register; err_cnt_o is tied to 0, and err_o and the FSM are unchanged.

## Structure
- Package knight_rider_pkg holds:
  - N_LED and N_RING constants
  - state enum (SEARCH, VERIFY, LOCKED)
  - index-to-LED fold function
- Sub-module kr_onehot_enc (combinational) takes counter_i and produces the index plus a valid flag. The decoder instantiates it once.

## Test plan
- Lock: after reset, apply a clean ring starting at 14'h0001, shifting one place per enabled cycle (LOCK_CNT=2). Expect locked_o=1 after the 3rd sample, with led_o=8'h04, pos_o=2, dir_o=0.
- Fold and wrap: run 30 enabled steps while locked. Expect led_o to sequence 01,02,…,80,40,…,02,01. dir_o=1 exactly for indices 8..13. No errors across the 13→0 wrap.
- Break: while locked at index 5, apply 14'h0100.
  - Expect a single err_o pulse, err_cnt_o=1, locked_o=0 and led_o=0 on the next cycle.
  - Expect re-lock after 3 clean samples.
- Invalid and hold:
  - Apply 14'h0000 and 14'h0003 while in SEARCH: the FSM stays in SEARCH and err_o stays 0.
  - Hold enable_i low for 5 cycles while locked: all outputs stay frozen.
- Saturation and config: with CNT_W=2 and the macro defined, force 5 breaks and expect err_cnt_o=3. With the macro undefined, err_cnt_o stays 0 while err_o still pulses.
- Async reset: assert sys_rst_i between clock edges while locked. Expect all outputs at 0 immediately, and re-lock after LOCK_CNT+1 clean samples following release.
